// File: rtl/hazard_pkg.sv
// Shared types for the forwarding / load-use hazard unit.
// Destination-tracking entry, stall FSM states, register constants.
package hazard_pkg;

  localparam int REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  RegWrite;
    logic                  MemRead;
  } dest_ent_t;

  localparam dest_ent_t ENT_NONE = '0;

  typedef enum logic {
    RUN,
    STALL
  } stall_state_t;

endpackage

// File: rtl/dest_track_pipe.sv
// Two-entry E/M destination tracker: clk, rst (async active-low),
// advance/bubble/flush controls, d_ent in, e_ent/m_ent out.
module dest_track_pipe
  import hazard_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      advance,
  input  logic      bubble,
  input  logic      flush,
  input  dest_ent_t d_ent,
  output dest_ent_t e_ent,
  output dest_ent_t m_ent
);

  logic kill;

  assign kill = bubble | flush;

  // M always receives whatever was in E; a killed slot enters E empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e_ent <= ENT_NONE;
      m_ent <= ENT_NONE;
    end else if (advance | kill) begin
      m_ent <= e_ent;
      e_ent <= kill ? ENT_NONE : d_ent;
    end
  end

endmodule

// File: rtl/forward_hazard_unit.sv
// Forward flags for E operands plus load-use stall/bubble control.
// In: clk, rst, D fields, E_branch_taken. Out: 4 flags, D_stall, E_bubble.
module forward_hazard_unit #(
  parameter int REG_ADDR_W        = 5,
  parameter int LOAD_STALL_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  D_valid,
  input  logic [REG_ADDR_W-1:0] D_rs1,
  input  logic [REG_ADDR_W-1:0] D_rs2,
  input  logic                  D_use_rs1,
  input  logic                  D_use_rs2,
  input  logic [REG_ADDR_W-1:0] D_rd,
  input  logic                  D_RegWrite,
  input  logic                  D_MemRead,
  input  logic                  E_branch_taken,
  output logic                  E_rs1_forward,
  output logic                  E_rs2_forward,
  output logic                  M_rs1_forward,
  output logic                  M_rs2_forward,
  output logic                  D_stall,
  output logic                  E_bubble
);

  import hazard_pkg::*;

  localparam logic [1:0] CNT_INIT =
    2'(LOAD_STALL_CYCLES - 1);

  dest_ent_t    d_ent;
  dest_ent_t    e_ent;
  dest_ent_t    m_ent;
  stall_state_t state;
  logic [1:0]   cnt;

  logic hit_e1, hit_e2;
  logic hit_m1, hit_m2;
  logic load_use;
  logic in_stall;
  logic kill;
  logic e1_nxt, e2_nxt;
  logic m1_nxt, m2_nxt;
  logic unused_m_ld;

  function automatic logic hit(
    input logic                  use_s,
    input logic [REG_ADDR_W-1:0] s,
    input dest_ent_t             ent
  );
    return use_s & ent.valid & ent.RegWrite
         & (ent.rd == s) & (s != ZERO_REG);
  endfunction

  assign d_ent = '{
    valid:    D_valid,
    rd:       D_rd,
    RegWrite: D_RegWrite,
    MemRead:  D_MemRead
  };

  assign unused_m_ld = m_ent.MemRead;

  assign hit_e1 = hit(D_use_rs1, D_rs1, e_ent);
  assign hit_e2 = hit(D_use_rs2, D_rs2, e_ent);
  assign hit_m1 = hit(D_use_rs1, D_rs1, m_ent);
  assign hit_m2 = hit(D_use_rs2, D_rs2, m_ent);

  assign load_use = D_valid & e_ent.MemRead
                  & (hit_e1 | hit_e2);

  assign in_stall = (state == STALL) | load_use;
  assign kill     = E_branch_taken | in_stall;

  assign D_stall  = in_stall & ~E_branch_taken;
  assign E_bubble = kill;

  // A load in E never forwards from E; that case stalls instead.
  assign e1_nxt = D_valid & hit_e1 & ~e_ent.MemRead;
  assign e2_nxt = D_valid & hit_e2 & ~e_ent.MemRead;
  assign m1_nxt = D_valid & hit_m1 & ~e1_nxt;
  assign m2_nxt = D_valid & hit_m2 & ~e2_nxt;

  dest_track_pipe u_track (
    .clk     (clk),
    .rst     (rst),
    .advance (1'b1),
    .bubble  (in_stall),
    .flush   (E_branch_taken),
    .d_ent   (d_ent),
    .e_ent   (e_ent),
    .m_ent   (m_ent)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      E_rs1_forward <= 1'b0;
      E_rs2_forward <= 1'b0;
      M_rs1_forward <= 1'b0;
      M_rs2_forward <= 1'b0;
    end else if (kill) begin
      E_rs1_forward <= 1'b0;
      E_rs2_forward <= 1'b0;
      M_rs1_forward <= 1'b0;
      M_rs2_forward <= 1'b0;
    end else begin
      E_rs1_forward <= e1_nxt;
      E_rs2_forward <= e2_nxt;
      M_rs1_forward <= m1_nxt;
      M_rs2_forward <= m2_nxt;
    end
  end

  // The detect cycle is the first bubble, so the counter
  // holds the number of bubbles still owed after it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      cnt   <= 2'd0;
    end else if (E_branch_taken) begin
      state <= RUN;
      cnt   <= 2'd0;
    end else if (state == STALL) begin
      cnt <= cnt - 2'd1;
      if (cnt == 2'd1) state <= RUN;
    end else if (load_use) begin
      cnt   <= CNT_INIT;
      state <= (LOAD_STALL_CYCLES > 1) ? STALL : RUN;
    end
  end

endmodule

// File: doc/forward_hazard_unit.md
Name: forward_hazard_unit

Overview:
- Produces the per-operand forward flags (E_rs1_forward, E_rs2_forward, M_rs1_forward, M_rs2_forward) consumed by the forwarding select logic, plus load-use stall and bubble controls.
- Tracks destination-register info of the instructions in E and M, and compares it against the D-stage source registers.
- Flags are registered so they are valid during the consuming instruction's E cycle.
- Sits between the decode stage and the E-stage operand muxes of the 5-stage core.

Parameters:
REG_ADDR_W, 5, register-address width.
LOAD_STALL_CYCLES, 1, bubbles inserted on a load-use hazard; legal range 1-3.

Ports:
clk  input  1  core clock; all state updates on rising edge.
rst  input  1  asynchronous, active-low reset.
D_valid  input  1  D holds a real instruction.
D_rs1  input  REG_ADDR_W  D source register 1.
D_rs2  input  REG_ADDR_W  D source register 2.
D_use_rs1  input  1  D instruction reads rs1.
D_use_rs2  input  1  D instruction reads rs2.
D_rd  input  REG_ADDR_W  D destination register.
D_RegWrite  input  1  D instruction writes rd.
D_MemRead  input  1  D instruction is a load.
E_branch_taken  input  1  redirect resolved in E; flush D and E.
E_rs1_forward  output  1  E rs1 takes the M-stage ALU result.
E_rs2_forward  output  1  E rs2 takes the M-stage ALU result.
M_rs1_forward  output  1  E rs1 takes the W-stage writeback data.
M_rs2_forward  output  1  E rs2 takes the W-stage writeback data.
D_stall  output  1  hold PC and the D register this cycle.
E_bubble  output  1  inject a NOP into E at the next edge.

Behaviour:
- Reset (rst low, asynchronous):
  - All four forward flags, D_stall, E_bubble = 0.
  - Tracked E/M entries invalid; FSM in RUN; stall counter = 0.
- Tracked entries: E_ent and M_ent, each {valid, rd, RegWrite, MemRead}.
- Each edge without stall: M_ent <= E_ent; E_ent <= D fields (valid = D_valid).
- Bubble or flush: E_ent is loaded invalid, while M_ent <= E_ent still occurs.
- Hit condition, per source s in {rs1, rs2}:
  - hitE(s) = D_use_s & E_ent.valid & E_ent.RegWrite & E_ent.rd == D_s & D_s != 0.
  - hitM(s) is the same test against M_ent.
- Flags are registered at the edge where the D instruction advances into E:
  - E_s_forward <= hitE(s) & !E_ent.MemRead.
  - M_s_forward <= hitM(s) & !E_s_forward_next.
  - When both hit, E wins; M is cleared so at most one flag per operand is set.
- Load-use hazard: hitE(s) & E_ent.MemRead for either used operand.
- FSM states:
  - RUN, load-use detected: D_stall=1 and E_bubble=1 combinationally; counter <= LOAD_STALL_CYCLES-1. Go to STALL if LOAD_STALL_CYCLES>1, else stay in RUN. The D instruction is re-evaluated next cycle with the load now in M, so it takes M_forward.
  - STALL: D_stall=1, E_bubble=1; counter decrements. Go to RUN when the counter reaches 0.
- While the unit stalls, its own flag registers and E_ent also take the bubble, so E flags are 0 for the bubble cycle.
- E_branch_taken has priority over everything:
  - E_ent <= invalid; flags <= 0; FSM -> RUN; counter <= 0; D_stall=0; E_bubble=1.
- x0 is never forwarded and never causes a stall.
- D_valid=0: flags <= 0 and no stall.
- A reset assertion mid-stall returns immediately to the reset state, with no pending stall.
- Combinational outputs (D_stall, E_bubble) have no paths from the flag registers. Zero-latency hazard detection; one-cycle latency for flags.

Decomposition:
- Shared package hazard_pkg holds:
  - REG_ADDR_W;
  - typedef dest_ent_t {valid, rd, RegWrite, MemRead};
  - FSM enum {RUN, STALL};
  - constant ZERO_REG = 0.
- Sub-module dest_track_pipe: the two-entry E/M shift register with advance, bubble and flush controls.
- Compare, flag and FSM logic stays in the top.

Test Plan:
- add x5 then sub using rs1=x5 back-to-back -> next cycle E_rs1_forward=1, M_rs1_forward=0, no stall.
- add x5, independent instruction, then use rs2=x5 -> M_rs2_forward=1, E_rs2_forward=0.
- lw x7 then add using x7 (LOAD_STALL_CYCLES=1) -> D_stall=1 and E_bubble=1 for exactly one cycle; then M_rs1_forward=1, E flags 0.
- Writers to x3 in both E and M, D reads x3 -> E_rs1_forward=1 only; and rd=x0 producer -> all flags 0.
- Load-use stall with LOAD_STALL_CYCLES=3, E_branch_taken asserted in the 2nd stall cycle -> D_stall drops that cycle, E_bubble=1, FSM RUN, flags 0.
- rst pulled low mid-STALL asynchronously -> all outputs 0 before next clk edge; after release a dependent pair still forwards correctly.
